regfile_mp: RTL

Parametrised multi-read-port register file for the DLX pipeline, the successor to the fixed 32×32 two-port file. Width, depth and read-port count are configurable. It adds write-to-read bypass, a sequential post-reset clear walk, and a pending-write scoreboard. Decode uses the scoreboard for RAW interlocks. Sits between decode (read/issue side) and writeback (write side).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_sb.sv | 43 ++++
 rtl/regfile_mp.sv | 108 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file and its users in decode.
package regfile_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_NRD   = 2;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  function automatic int rf_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Pending-write scoreboard: one busy bit per register, set-wins priority, registered lookups.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = RF_NRD,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hold,
  input  logic              i_set_en,
  input  logic [AW-1:0]     i_set_idx,
  input  logic              i_clr_en,
  input  logic [AW-1:0]     i_clr_idx,
  input  logic [NRD*AW-1:0] i_rs,
  output logic [NRD-1:0]    o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nx;

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    w_busy_nx = r_busy;
    if (i_clr_en) w_busy_nx[i_clr_idx] = 1'b0;
    if (i_set_en) w_busy_nx[i_set_idx] = 1'b1;
    w_busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
      o_busy <= '0;
    end else begin
      r_busy <= w_busy_nx;
      for (int i = 0; i < NRD; i++) begin
        o_busy[i] <= i_hold ? 1'b0 : w_busy_nx[i_rs[i*AW +: AW]];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-first bypass, post-reset clear walk
// and a pending-write scoreboard for decode RAW interlocks.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = RF_NRD,
  localparam int AW   = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                WB,
  input  logic                reg_s_enable,
  input  logic [AW-1:0]       Rd,
  input  logic [XLEN-1:0]     reg_s,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] S,
  output logic [NRD-1:0]      rs_busy,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_rd,
  output logic                ready,
  output rf_state_t           o_dbg_state
);

  rf_state_t       r_state;
  rf_state_t       w_state_nx;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nx;
  logic            w_we;
  logic            w_issue;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] w_rd   [NRD];

  // Handshake: no back-pressure; a write or issue is taken on any edge where it is
  // presented with ready=1, and is silently lost otherwise.
  assign ready       = (r_state == RF_RUN);
  assign o_dbg_state = r_state;
  assign w_we        = WB & reg_s_enable & ready & (Rd != '0);
  assign w_issue     = issue_en & ready & (issue_rd != '0);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      RF_CLEAR: begin
        w_cnt_nx = r_cnt + 1'b1;
        if (r_cnt == AW'(NREGS - 1)) w_state_nx = RF_RUN;
      end
      RF_RUN:   w_state_nx = RF_RUN;
      default:  w_state_nx = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Storage has no reset of its own; the walk zeroes it one entry per edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == RF_CLEAR) r_regs[r_cnt] <= '0;
      else if (w_we)           r_regs[Rd]    <= reg_s;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      w_rd[i] = '0;
      if (rs[i*AW +: AW] != '0) begin
        w_rd[i] = (w_we && (Rd == rs[i*AW +: AW])) ? reg_s : r_regs[rs[i*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (r_state == RF_CLEAR)) begin
      S <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        S[i*XLEN +: XLEN] <= w_rd[i];
      end
    end
  end

  regfile_sb #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_hold    (~ready),
    .i_set_en  (w_issue),
    .i_set_idx (issue_rd),
    .i_clr_en  (w_we),
    .i_clr_idx (Rd),
    .i_rs      (rs),
    .o_busy    (rs_busy)
  );

endmodule
